// File: rtl/ccff_chain_loader.sv
// Serial loader for the tile configuration chain: shifts CHAIN_LEN bits in from a word stream,
// then recirculates the chain once and compares CRCs of written vs. returned bits.
module ccff_chain_loader #(
  parameter  int CHAIN_LEN = 64,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(CHAIN_LEN + 1)
) (
  input  logic              prog_clk,
  input  logic              pReset,
  input  logic              start,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  input  logic              ccff_tail,
  output logic              ccff_shift_en,
  output logic              busy,
  output logic              done,
  output logic              crc_ok
);

  localparam int IDX_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LOAD   = 2'd1;
  localparam logic [1:0] S_VERIFY = 2'd2;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CHAIN_LEN - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(WORD_W - 1);
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  logic [1:0]        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [WORD_W-1:0] r_buf;
  logic [IDX_W-1:0]  r_bidx;
  logic              r_bvld;
  logic [15:0]       r_wr_crc;
  logic [15:0]       r_rd_crc;
  logic              r_done;
  logic              r_crc_ok;

  logic        w_load, w_verify, w_load_shift, w_last, w_buf_bit, w_buf_last, w_accept;
  logic [15:0] w_wr_crc_nxt, w_rd_crc_nxt;

  function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
    crc_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
  endfunction

  assign w_load       = (r_state == S_LOAD);
  assign w_verify     = (r_state == S_VERIFY);
  assign w_buf_bit    = r_buf[r_bidx];
  assign w_buf_last   = (r_bidx == IDX_LAST);
  assign w_load_shift = w_load & r_bvld;
  assign w_last       = (r_cnt == CNT_LAST);
  assign w_wr_crc_nxt = crc_step(r_wr_crc, w_buf_bit);
  assign w_rd_crc_nxt = crc_step(r_rd_crc, ccff_tail);

  // Refill while the last buffered bit goes out, but never on the final chain bit.
  assign cfg_ready     = w_load & (~r_bvld | (w_buf_last & ~w_last));
  assign w_accept      = cfg_valid & cfg_ready;
  assign ccff_shift_en = w_load_shift | w_verify;
  assign ccff_head     = w_verify ? ccff_tail : (w_load_shift & w_buf_bit);
  assign busy          = (r_state != S_IDLE);
  assign done          = r_done;
  assign crc_ok        = r_crc_ok;

  always_ff @(posedge prog_clk or posedge pReset) begin
    if (pReset) begin
      r_state  <= S_IDLE;
      r_cnt    <= '0;
      r_buf    <= '0;
      r_bidx   <= '0;
      r_bvld   <= 1'b0;
      r_wr_crc <= CRC_INIT;
      r_rd_crc <= CRC_INIT;
      r_done   <= 1'b0;
      r_crc_ok <= 1'b0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_state  <= S_LOAD;
            r_cnt    <= '0;
            r_wr_crc <= CRC_INIT;
            r_rd_crc <= CRC_INIT;
            r_crc_ok <= 1'b0;
          end
        end
        S_LOAD: begin
          if (w_load_shift) begin
            r_wr_crc <= w_wr_crc_nxt;
            r_cnt    <= w_last ? '0 : r_cnt + CNT_W'(1);
            if (w_last) r_state <= S_VERIFY;
          end
          // Leftover bits of the final word are dropped at the LOAD->VERIFY edge.
          if (w_load_shift && w_last) begin
            r_bvld <= 1'b0;
          end else if (w_accept) begin
            r_buf  <= cfg_data;
            r_bidx <= '0;
            r_bvld <= 1'b1;
          end else if (w_load_shift) begin
            if (w_buf_last) r_bvld <= 1'b0;
            else            r_bidx <= r_bidx + IDX_W'(1);
          end
        end
        S_VERIFY: begin
          r_rd_crc <= w_rd_crc_nxt;
          if (w_last) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_done   <= 1'b1;
            r_crc_ok <= (w_rd_crc_nxt == r_wr_crc);
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ccff_chain_loader.sv
// Bench for ccff_chain_loader: a 10-bit and a 1-bit chain model, directed scenarios plus random
// words/valid gaps, checked against bit-list and CRC reference computations.
module tb_ccff_chain_loader;
  localparam int N = 10;
  localparam int W = 8;
  localparam logic [N-1:0] FLIP = N'(16);

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  int n_cmp = 0;
  int n_bad = 0;

  // ---- CHAIN_LEN=10 harness ----
  logic st10 = 1'b0, v10 = 1'b0;
  logic rdy10, hd10, sen10, bz10, dn10, ok10, tl10;
  logic [W-1:0] d10;
  logic [W-1:0] wd10 [4];
  logic [N-1:0] ch10 = '0;
  int sh10 = 0, wi10 = 0, stall10 = 0;
  bit flip_arm = 1'b0;

  assign tl10 = ch10[N-1];
  assign d10  = wd10[wi10[1:0]];

  ccff_chain_loader #(.CHAIN_LEN(N), .WORD_W(W)) u_dut10 (
    .prog_clk(clk), .pReset(rst), .start(st10), .cfg_data(d10), .cfg_valid(v10),
    .cfg_ready(rdy10), .ccff_head(hd10), .ccff_tail(tl10), .ccff_shift_en(sen10),
    .busy(bz10), .done(dn10), .crc_ok(ok10));

  // Chain model: index 0 sits at the head, N-1 drives the tail.
  always @(posedge clk) begin
    if (sen10) begin
      ch10 <= {ch10[N-2:0], hd10} ^ ((flip_arm && sh10 == N-1) ? FLIP : '0);
      sh10 <= sh10 + 1;
    end
    if (v10 && rdy10) wi10 <= wi10 + 1;
    if (bz10 && !sen10) stall10 <= stall10 + 1;
    if (st10 && !bz10) begin
      sh10 <= 0; wi10 <= 0; stall10 <= 0;
    end
  end

  // ---- CHAIN_LEN=1 harness ----
  logic st1 = 1'b0, v1 = 1'b0;
  logic rdy1, hd1, sen1, bz1, dn1, ok1;
  logic [W-1:0] wd1 = '0;
  logic ch1 = 1'b0;
  int sh1 = 0, wi1 = 0;

  ccff_chain_loader #(.CHAIN_LEN(1), .WORD_W(W)) u_dut1 (
    .prog_clk(clk), .pReset(rst), .start(st1), .cfg_data(wd1), .cfg_valid(v1),
    .cfg_ready(rdy1), .ccff_head(hd1), .ccff_tail(ch1), .ccff_shift_en(sen1),
    .busy(bz1), .done(dn1), .crc_ok(ok1));

  always @(posedge clk) begin
    if (sen1) begin
      ch1 <= hd1; sh1 <= sh1 + 1;
    end
    if (v1 && rdy1) wi1 <= wi1 + 1;
    if (st1 && !bz1) begin
      sh1 <= 0; wi1 <= 0;
    end
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // CRC-16/CCITT over a bit list, first element first.
  function automatic logic [15:0] crc_bits(input bit q[$]);
    int c = 'hFFFF;
    foreach (q[i]) begin
      c = c ^ (int'(q[i]) << 15);
      c = (c & 'h8000) ? ((c << 1) ^ 'h1021) : (c << 1);
      c = c & 'hFFFF;
    end
    return c[15:0];
  endfunction

  // One pass on the 10-bit chain. gap: cycles cfg_valid is dropped once the first word is taken.
  task automatic pass10(input string tag, input bit flip, input int gap, input bit rnd,
                        input int sa, input int sb, input int exp_lat, input int exp_stall);
    bit wr[$];
    bit rd[$];
    logic [N-1:0] exp_ch;
    int lat, np, gapc;
    lat = 0; np = 0; gapc = 0; exp_ch = '0;
    for (int k = 0; k < N; k++) begin
      wr.push_back(wd10[k / W][k % W]);
      exp_ch[N-1-k] = wd10[k / W][k % W];
    end
    rd = wr;
    if (flip) begin
      rd[N-1-4] = ~rd[N-1-4];
      exp_ch = exp_ch ^ FLIP;
    end
    flip_arm = flip;
    @(negedge clk);
    st10 = 1'b1; v10 = 1'b1;
    for (int k = 1; k <= 200; k++) begin
      @(negedge clk);
      st10 = (k == sa || k == sb);
      if (gap > 0 && wi10 == 1 && gapc < gap) begin
        v10 = 1'b0; gapc++;
      end else begin
        v10 = rnd ? ($urandom_range(0, 2) != 0) : 1'b1;
      end
      if (dn10) begin
        np++;
        if (lat == 0) lat = k;
      end
      if (lat != 0 && k >= lat + 5) break;
    end
    v10 = 1'b0; st10 = 1'b0; flip_arm = 1'b0;
    chk({tag, " done pulses"}, np, 1);
    if (exp_lat > 0) chk({tag, " latency"}, lat, exp_lat);
    else             chk({tag, " done seen"}, lat != 0, 1);
    chk({tag, " crc_ok"}, ok10, crc_bits(wr) == crc_bits(rd));
    chk({tag, " chain"}, ch10, exp_ch);
    chk({tag, " shifts"}, sh10, 2 * N);
    chk({tag, " words taken"}, wi10, (N + W - 1) / W);
    chk({tag, " busy after"}, bz10, 0);
    if (exp_stall >= 0) chk({tag, " stall cycles"}, stall10, exp_stall);
  endtask

  task automatic pass1(input string tag, input logic [W-1:0] w);
    int lat, np;
    lat = 0; np = 0;
    wd1 = w;
    @(negedge clk);
    st1 = 1'b1; v1 = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      st1 = 1'b0;
      if (dn1) begin
        np++;
        if (lat == 0) lat = k;
      end
      if (lat != 0 && k >= lat + 3) break;
    end
    v1 = 1'b0;
    chk({tag, " latency"}, lat, 4);
    chk({tag, " done pulses"}, np, 1);
    chk({tag, " crc_ok"}, ok1, 1);
    chk({tag, " chain"}, ch1, w[0]);
    chk({tag, " shifts"}, sh1, 2);
    chk({tag, " words taken"}, wi1, 1);
  endtask

  initial begin
    rst = 1'b1;
    for (int i = 0; i < 4; i++) wd10[i] = '0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst busy", bz10, 0);
    chk("rst done", dn10, 0);
    chk("rst crc_ok", ok10, 0);
    chk("rst cfg_ready", rdy10, 0);
    chk("rst shift_en", sen10, 0);
    chk("rst head", hd10, 0);
    chk("rst1 busy", bz1, 0);
    chk("rst1 shift_en", sen1, 0);

    wd10[0] = 8'hA5; wd10[1] = 8'h03;
    pass10("base", 0, 0, 0, 0, 0, 22, 1);
    chk("base chain literal", ch10, 10'b1010010111);
    pass10("flip", 1, 0, 0, 0, 0, 22, 1);
    chk("flip crc_ok low", ok10, 0);
    pass10("gap", 0, 12, 0, 0, 0, 27, 6);
    chk("gap chain literal", ch10, 10'b1010010111);
    pass10("restart", 0, 0, 0, 5, 15, 22, 1);

    // Reset in the middle of LOAD.
    wd10[0] = 8'($urandom); wd10[1] = 8'($urandom);
    @(negedge clk);
    st10 = 1'b1; v10 = 1'b1;
    @(negedge clk);
    st10 = 1'b0;
    for (int k = 0; k < 40 && sh10 < 6; k++) @(negedge clk);
    chk("mid shifts", sh10, 6);
    chk("mid shift_en", sen10, 1);
    rst = 1'b1;
    #1;
    chk("arst shift_en", sen10, 0);
    chk("arst busy", bz10, 0);
    chk("arst cfg_ready", rdy10, 0);
    chk("arst crc_ok", ok10, 0);
    @(negedge clk);
    rst = 1'b0; v10 = 1'b0;
    @(negedge clk);
    chk("arst chain held", sh10, 6);
    pass10("post-rst", 0, 0, 0, 0, 0, 22, 1);

    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 4; i++) wd10[i] = 8'($urandom);
      pass10($sformatf("rnd%0d", r), bit'($urandom_range(0, 1)), 0, 1, 0, 0, -1, -1);
    end

    pass1("len1 w01", 8'h01);
    pass1("len1 w00", 8'hFE);
    pass1("len1 rnd", 8'($urandom));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
